// File: rtl/key_scheduler.sv
`default_nettype none
// ============================================================================
// key_scheduler : AES-128 key expansion, one full round key per cycle, stored
//                 in 11 slots and read back in decryption order.
// Option macro   : KEY_SCHEDULER_OUT_REG_EN (registers round_key_o, 1-cycle lat)
// Revision       : 1.0
// ============================================================================
module key_scheduler (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_valid_i,
    input  logic [127:0] key_i,
    input  logic [3:0]   round_sel_i,
    output logic         key_ready_o,
    output logic         busy_o,
    output logic [127:0] round_key_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state;
    logic [3:0]   round;
    logic [127:0] rk [0:10];

    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [127:0] sel_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  temp;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        prev_key = '0;
        for (int i = 1; i <= 10; i++) begin
            if (round == 4'(i)) prev_key = rk[i-1];
        end
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        w0   = prev_key[127:96];
        w1   = prev_key[95:64];
        w2   = prev_key[63:32];
        w3   = prev_key[31:0];
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Decryption order: select 0 is the last round key
    always_comb begin
        sel_key = '0;
        for (int i = 0; i <= 10; i++) begin
            if (round_sel_i == 4'(i)) sel_key = rk[10-i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            round       <= '0;
            busy_o      <= 1'b0;
            key_ready_o <= 1'b0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (key_valid_i) begin
                        rk[0]       <= key_i;
                        round       <= 4'd1;
                        state       <= EXPAND;
                        busy_o      <= 1'b1;
                        key_ready_o <= 1'b0;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (round == 4'(i)) rk[i] <= next_key;
                    end
                    round <= round + 4'd1;
                    if (round == 4'd10) begin
                        state       <= READY;
                        busy_o      <= 1'b0;
                        key_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    round       <= '0;
                    busy_o      <= 1'b0;
                    key_ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_SCHEDULER_OUT_REG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) round_key_o <= '0;
        else         round_key_o <= sel_key;
    end
`else
    assign round_key_o = sel_key;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_scheduler.sv
`default_nettype none
// ============================================================================
// tb_key_scheduler : randomized and directed checks of key_scheduler against a
//                    word-level FIPS-197 key expansion model.
// Revision         : 1.0
// ============================================================================
module tb_key_scheduler;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         key_valid_i;
    logic [127:0] key_i;
    logic [3:0]   round_sel_i;
    logic         key_ready_o;
    logic         busy_o;
    logic [127:0] round_key_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    key_scheduler dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_valid_i (key_valid_i),
        .key_i       (key_i),
        .round_sel_i (round_sel_i),
        .key_ready_o (key_ready_o),
        .busy_o      (busy_o),
        .round_key_o (round_key_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box table: brute-force inverse search, then the bitwise affine formula
    initial begin
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a] = s;
        end
    end

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Round key n of key k, from the 44-word FIPS-197 expansion loop
    function automatic logic [127:0] sched(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_busy = 1'b0;
    logic         m_ready = 1'b0;
    logic         m_ready_prev = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_vis [11];
    logic [127:0] m_pend [11];
    logic [127:0] m_out_reg = '0;

    function automatic logic [127:0] pick(input logic [3:0] s);
        if (int'(s) <= 10) return m_vis[10 - int'(s)];
        return '0;
    endfunction

    initial begin
        for (int n = 0; n < 11; n++) m_vis[n] = '0;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_busy = 1'b0; m_ready = 1'b0; m_ready_prev = 1'b0;
                m_cnt = 0; m_out_reg = '0;
                for (int n = 0; n < 11; n++) m_vis[n] = '0;
            end else begin
                m_ready_prev = m_ready;
                m_out_reg    = pick(round_sel_i);
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 1'b0;
                        m_ready = 1'b1;
                        for (int n = 0; n < 11; n++) m_vis[n] = m_pend[n];
                    end
                end else if (key_valid_i) begin
                    for (int n = 0; n < 11; n++) m_pend[n] = sched(key_i, n);
                    m_busy = 1'b1; m_ready = 1'b0; m_cnt = 10;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            check("busy", 128'(busy_o), 128'(m_busy));
            check("ready", 128'(key_ready_o), 128'(m_ready));
`ifdef KEY_SCHEDULER_OUT_REG_EN
            if (m_ready && m_ready_prev) check("round_key_reg", round_key_o, m_out_reg);
`else
            if (m_ready) check("round_key_comb", round_key_o, pick(round_sel_i));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic pulse(input logic [127:0] k);
        @(negedge clk_i);
        key_i = k;
        key_valid_i = 1'b1;
        @(negedge clk_i);
        key_valid_i = 1'b0;
    endtask

    task automatic wait_ready(input int start);
        int g;
        g = 0;
        while (!key_ready_o && g < 40) begin
            @(negedge clk_i);
            g++;
        end
        check("latency", 128'(cyc - start), 128'd10);
        check("ready_up", 128'(key_ready_o), 128'd1);
    endtask

    task automatic sel_check(input string name, input logic [3:0] s, input logic [127:0] exp);
        @(negedge clk_i);
        round_sel_i = s;
        @(posedge clk_i);
        #2;
        check(name, round_key_o, exp);
    endtask

    initial begin
        int start;
        rst_ni = 1'b0;
        key_valid_i = 1'b0;
        key_i = '0;
        round_sel_i = '0;
        #1;
        check("reset_busy", 128'(busy_o), 128'd0);
        check("reset_ready", 128'(key_ready_o), 128'd0);
        check("reset_rk", round_key_o, 128'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // FIPS-197 key
        pulse(K1);
        start = cyc;
        check("busy_after_load", 128'(busy_o), 128'd1);
        wait_ready(start);
        sel_check("fips_sel0", 4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sel_check("fips_sel9", 4'd9, 128'ha0fafe1788542cb123a339392a6c7605);
        sel_check("fips_sel10", 4'd10, K1);
        sel_check("fips_sel12", 4'd12, 128'd0);

        // Output latency of the select
        sel_check("lat_sel0", 4'd0, sched(K1, 10));
        @(negedge clk_i);
        round_sel_i = 4'd1;
        #1;
`ifdef KEY_SCHEDULER_OUT_REG_EN
        check("lat_sel1_early", round_key_o, sched(K1, 10));
`else
        check("lat_sel1_early", round_key_o, sched(K1, 9));
`endif
        @(posedge clk_i);
        #2;
        check("lat_sel1", round_key_o, sched(K1, 9));
        @(negedge clk_i);
        round_sel_i = 4'd2;
        #1;
`ifdef KEY_SCHEDULER_OUT_REG_EN
        check("lat_sel2_early", round_key_o, sched(K1, 9));
`else
        check("lat_sel2_early", round_key_o, sched(K1, 8));
`endif
        @(posedge clk_i);
        #2;
        check("lat_sel2", round_key_o, sched(K1, 8));

        // Reload during EXPAND is ignored
        pulse(K1);
        start = cyc;
        repeat (2) @(negedge clk_i);
        pulse(K2);
        wait_ready(start);
        sel_check("ignore_sel0", 4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reload from READY restarts
        pulse(K2);
        start = cyc;
        check("restart_ready_low", 128'(key_ready_o), 128'd0);
        check("restart_busy", 128'(busy_o), 128'd1);
        wait_ready(start);
        sel_check("k2_sel0", 4'd0, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset mid-EXPAND
        pulse(K1);
        repeat (4) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_busy", 128'(busy_o), 128'd0);
        check("rst_mid_ready", 128'(key_ready_o), 128'd0);
        check("rst_mid_rk", round_key_o, 128'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        check("post_rst_busy", 128'(busy_o), 128'd0);
        check("post_rst_ready", 128'(key_ready_o), 128'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            key_valid_i = ($urandom_range(0, 15) == 0);
            key_i = {$urandom, $urandom, $urandom, $urandom};
            round_sel_i = 4'($urandom_range(0, 15));
        end
        @(negedge clk_i);
        key_valid_i = 1'b0;
        repeat (15) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
